// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared types and constants for the restoring divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Wide enough to truncate to any supported operand width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/restoring_divider_if.sv
// rtl/restoring_divider_if.sv - start/done handshake and operand/result bundle
interface restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Busy, Done, Quotient, Remainder, DivByZero
  );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/restoring_divider_trial_subtractor.sv
// rtl/restoring_divider_trial_subtractor.sv - (WIDTH+1)-bit ripple a-b with sign output
module trial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           sign
);

  logic [WIDTH+1:0] carry;
  logic             carry_out_unused;

  // Two's-complement subtract: invert b and inject a carry of one.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  assign sign             = diff[WIDTH];
  assign carry_out_unused = carry[WIDTH+1];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned divider, one quotient bit per clock
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  restoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r, shifted, trial, r_next;
  logic [WIDTH-1:0] q, d, q_next;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div_by_zero;
  logic             trial_neg;
  logic             accept, last_iter;
  logic             r_msb_unused;

  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};

  trial_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a   (shifted),
    .b   ({1'b0, d}),
    .diff(trial),
    .sign(trial_neg)
  );

  // Negative trial means the divisor did not fit: keep the shifted value.
  assign r_next       = trial_neg ? shifted : trial;
  assign q_next       = {q[WIDTH-2:0], ~trial_neg};
  assign accept       = (state == IDLE) && bus.Start;
  assign last_iter    = (state == CALC) && (count == CW'(WIDTH - 1));
  assign r_msb_unused = r[WIDTH];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_next = (bus.Divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count       <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d     <= bus.Divisor;
      q     <= bus.Dividend;
      r     <= '0;
      count <= '0;
      // Zero divisor skips the iterations and publishes results at once.
      if (bus.Divisor == '0) begin
        div_by_zero <= 1'b1;
        quotient    <= WIDTH'(DIV0_QUOTIENT);
        remainder   <= bus.Dividend;
      end
    end else if (state == CALC) begin
      r     <= r_next;
      q     <= q_next;
      count <= count + 1'b1;
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

  assign bus.Busy      = (state == CALC);
  assign bus.Done      = (state == DONE);
  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.DivByZero = div_by_zero;

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned divider: one quotient bit per clock by restoring shift-subtract.
- Inverse companion to the team's shift-add multiplier datapath; reuses the same (WIDTH+1)-bit trial-subtract idea.
- Sits beside the multiplier in the lab top level and is driven by the same Start/Done control style.
- Results are held on outputs until the next accepted Start.

Parameters:
WIDTH, 8, operand width of dividend, divisor, quotient and remainder

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-low reset (0 = reset)
Start  input  1  request; sampled only in IDLE
Dividend  input  WIDTH  unsigned dividend; captured on accepted Start edge
Divisor  input  WIDTH  unsigned divisor; captured on accepted Start edge
Busy  output  1  high while in CALC
Done  output  1  one-cycle pulse while in DONE
Quotient  output  WIDTH  result quotient
Remainder  output  WIDTH  result remainder
DivByZero  output  1  set when the captured divisor was 0; held with results

Behaviour:
- Reset (Reset==0 at an edge, any state, including mid-CALC): state=IDLE, count=0, internal R/Q/D registers=0. Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0. Any in-progress division is aborted.
- States: IDLE, CALC, DONE. Outputs are decoded from state: Busy=(state==CALC), Done=(state==DONE).
- IDLE, Start=1 at edge k:
  - Latch D=Divisor, Q=Dividend, R=0 (WIDTH+1 bits), count=0.
  - If Divisor==0: go to DONE. DivByZero=1, Quotient=all-ones, Remainder=Dividend. Done is high in cycle k+1.
  - Otherwise: DivByZero=0, go to CALC.
- CALC, one iteration per edge:
  - Form shifted = {R[WIDTH-1:0], Q[WIDTH-1]} and trial = shifted − {0,D}, both (WIDTH+1) bits.
  - If trial[WIDTH]==0: R=trial, Q={Q[WIDTH-2:0],1}.
  - Else (restore): R=shifted, Q={Q[WIDTH-2:0],0}.
  - count increments each iteration. On the iteration where count==WIDTH-1, go to DONE and load Quotient=final Q, Remainder=final R[WIDTH-1:0].
- Latency: the accepting edge is k. Iterations run on edges k+1..k+WIDTH. Done is high in the cycle after edge k+WIDTH (9 cycles after the Start edge for WIDTH=8). Busy is high for exactly WIDTH cycles.
- DONE: unconditional return to IDLE at the next edge. Start is ignored in DONE and in CALC, so no queuing. A Start held high continuously re-triggers on the first IDLE edge, giving back-to-back operations with a one-cycle IDLE gap.
- Quotient, Remainder and DivByZero change only at the DONE-entry edge or on reset. They are stable throughout CALC of the next operation.
- Dividend and Divisor may change freely after the accepting edge.
- Invariant on completion: Dividend == Quotient*Divisor + Remainder, with Remainder < Divisor.

Decomposition:
- Shared package div_pkg:
  - state enum div_state_t {IDLE, CALC, DONE}
  - localparam count width = $clog2(WIDTH)
  - localparam DIV0_QUOTIENT = all-ones
- One sub-module, trial_subtractor: (WIDTH+1)-bit combinational A−B with a borrow/sign output, built as a ripple of the team's existing full_adder cells with B inverted and carry-in=1.
- FSM, counter and R/Q/D registers stay in restoring_divider.

Test Plan:
- 100/7, Start pulse at edge k -> Busy high cycles k+1..k+8; Done only at k+9; Quotient=14, Remainder=2, DivByZero=0.
- 255/1, then 255/255, then 5/200 -> (255,0), (1,0), (0,5) respectively; outputs hold between operations.
- 200/0 -> Done at k+1, Busy never high; Quotient=255, Remainder=200, DivByZero=1. A following 9/3 clears DivByZero and gives (3,0).
- Start toggled every cycle during CALC, operands changed at k+3 -> result still from the original operands; exactly one Done pulse.
- Reset=0 at iteration 4 of 100/7 -> next cycle IDLE, all outputs 0. A subsequent 77/10 gives (7,7) with normal latency.
- Randomised sweep of 2000 operand pairs with a scoreboard checking the completion invariant and exact latency of WIDTH+1 cycles (1 for divisor 0).
